// File: rtl/stomp_resolver_if.sv
// Bundle between the game logic and the stomp resolver: frame strobe, player and
// enemy geometry in, per-enemy and player state flags plus event strobes out.
interface stomp_resolver_if #(
  parameter int N_ENEMY = 4,
  parameter int W       = 13,
  parameter int LIVES   = 3
);
  localparam int LW = $clog2(LIVES + 1);

  logic                 frame_tick;
  logic                 clear_all;
  logic [W-1:0]         player_x;
  logic [W-1:0]         player_y;
  logic [W-1:0]         player_y_motion;
  logic [N_ENEMY*W-1:0] enemy_x;
  logic [N_ENEMY*W-1:0] enemy_y;
  logic [N_ENEMY-1:0]   enemy_active;
  logic [N_ENEMY-1:0]   enemy_alive;
  logic [N_ENEMY-1:0]   enemy_squashed;
  logic                 player_hurt;
  logic                 player_dead;
  logic [LW-1:0]        lives;
  logic                 stomp_pulse;
  logic                 hit_pulse;

  modport master (
    output frame_tick, clear_all, player_x, player_y, player_y_motion,
           enemy_x, enemy_y, enemy_active,
    input  enemy_alive, enemy_squashed, player_hurt, player_dead, lives,
           stomp_pulse, hit_pulse
  );

  modport slave (
    input  frame_tick, clear_all, player_x, player_y, player_y_motion,
           enemy_x, enemy_y, enemy_active,
    output enemy_alive, enemy_squashed, player_hurt, player_dead, lives,
           stomp_pulse, hit_pulse
  );
endinterface

// File: rtl/stomp_resolver.sv
// Once per frame, resolves player/enemy contact into stomps (player falling) or
// hits (player not falling), tracking each enemy's life cycle and the player's lives.
module stomp_resolver #(
  parameter int N_ENEMY       = 4,
  parameter int W             = 13,
  parameter int P_SIZE        = 32,
  parameter int E_SIZE        = 32,
  parameter int SQUASH_FRAMES = 30,
  parameter int IFRAMES       = 60,
  parameter int LIVES         = 3
) (
  input logic             Clk,
  input logic             Reset,
  stomp_resolver_if.slave sr
);
  localparam int LW  = $clog2(LIVES + 1);
  localparam int SQW = $clog2(SQUASH_FRAMES + 1);
  localparam int IFW = $clog2(IFRAMES + 1);

  localparam logic [W:0]     P_SZ    = (W+1)'(P_SIZE);
  localparam logic [W:0]     E_SZ    = (W+1)'(E_SIZE);
  localparam logic [SQW-1:0] SQ_LOAD = SQW'(SQUASH_FRAMES);
  localparam logic [SQW-1:0] SQ_ONE  = SQW'(1);
  localparam logic [IFW-1:0] IF_LOAD = IFW'(IFRAMES);
  localparam logic [IFW-1:0] IF_ONE  = IFW'(1);
  localparam logic [LW-1:0]  LV_LOAD = LW'(LIVES);
  localparam logic [LW-1:0]  LV_ONE  = LW'(1);

  typedef enum logic [1:0] {E_IDLE = 2'd0, E_ALIVE = 2'd1, E_SQUASHED = 2'd2, E_DEAD = 2'd3} enemy_state_e;
  typedef enum logic [1:0] {P_ALIVE = 2'd0, P_HURT = 2'd1, P_DEAD = 2'd2} player_state_e;

  enemy_state_e   enemy_q  [N_ENEMY];
  enemy_state_e   enemy_d  [N_ENEMY];
  logic [SQW-1:0] sq_cnt_q [N_ENEMY];
  logic [SQW-1:0] sq_cnt_d [N_ENEMY];
  player_state_e  player_q, player_d;
  logic [IFW-1:0] if_cnt_q, if_cnt_d;
  logic [LW-1:0]  lives_q, lives_d;
  logic           stomp_q, stomp_d, hit_q, hit_d;
  logic           hurt_q, dead_q;
  logic [N_ENEMY-1:0] alive_q, squashed_q;

  logic [W:0]         px_s, py_s;
  logic [W:0]         ex_s [N_ENEMY];
  logic [W:0]         ey_s [N_ENEMY];
  logic [N_ENEMY-1:0] overlap_s, contact_s;
  logic               falling_s, hit_s, stomp_s;

  // Geometry: sums are one bit wider so boxes near the right/bottom edge never wrap.
  always_comb begin
    px_s      = {1'b0, sr.player_x};
    py_s      = {1'b0, sr.player_y};
    falling_s = (sr.player_y_motion != {W{1'b0}}) && !sr.player_y_motion[W-1];
    for (int i = 0; i < N_ENEMY; i++) begin
      ex_s[i]      = {1'b0, sr.enemy_x[i*W +: W]};
      ey_s[i]      = {1'b0, sr.enemy_y[i*W +: W]};
      overlap_s[i] = (px_s < ex_s[i] + E_SZ) && (ex_s[i] < px_s + P_SZ) &&
                     (py_s < ey_s[i] + E_SZ) && (ey_s[i] < py_s + P_SZ);
      // An enemy being despawned this frame takes no part in contact.
      contact_s[i] = overlap_s[i] && sr.enemy_active[i] && (enemy_q[i] == E_ALIVE);
    end
    stomp_s = (player_q != P_DEAD) && falling_s && (|contact_s);
    hit_s   = (player_q == P_ALIVE) && !falling_s && (|contact_s);
  end

  // Next-state for all enemy and player FSMs; clear_all outranks frame_tick.
  always_comb begin
    enemy_d  = enemy_q;
    sq_cnt_d = sq_cnt_q;
    player_d = player_q;
    if_cnt_d = if_cnt_q;
    lives_d  = lives_q;
    stomp_d  = 1'b0;
    hit_d    = 1'b0;
    if (sr.clear_all) begin
      for (int i = 0; i < N_ENEMY; i++) begin
        enemy_d[i]  = E_IDLE;
        sq_cnt_d[i] = {SQW{1'b0}};
      end
    end else if (sr.frame_tick) begin
      for (int i = 0; i < N_ENEMY; i++) begin
        case (enemy_q[i])
          E_IDLE: begin
            if (sr.enemy_active[i]) enemy_d[i] = E_ALIVE;
            else                    enemy_d[i] = E_IDLE;
          end
          E_ALIVE: begin
            if (!sr.enemy_active[i]) begin
              enemy_d[i] = E_IDLE;
            end else if (stomp_s && contact_s[i]) begin
              enemy_d[i]  = E_SQUASHED;
              sq_cnt_d[i] = SQ_LOAD;
            end else begin
              enemy_d[i] = E_ALIVE;
            end
          end
          E_SQUASHED: begin
            if (sq_cnt_q[i] == SQ_ONE) begin
              enemy_d[i]  = E_DEAD;
              sq_cnt_d[i] = {SQW{1'b0}};
            end else begin
              sq_cnt_d[i] = sq_cnt_q[i] - SQ_ONE;
            end
          end
          E_DEAD:  enemy_d[i] = E_DEAD;
          default: enemy_d[i] = E_IDLE;
        endcase
      end
      stomp_d = stomp_s;
      case (player_q)
        P_ALIVE: begin
          if (hit_s) begin
            hit_d = 1'b1;
            if (lives_q == LV_ONE) begin
              player_d = P_DEAD;
              lives_d  = {LW{1'b0}};
            end else begin
              player_d = P_HURT;
              lives_d  = lives_q - LV_ONE;
              if_cnt_d = IF_LOAD;
            end
          end else begin
            player_d = P_ALIVE;
          end
        end
        P_HURT: begin
          if (if_cnt_q == IF_ONE) begin
            player_d = P_ALIVE;
            if_cnt_d = {IFW{1'b0}};
          end else begin
            if_cnt_d = if_cnt_q - IF_ONE;
          end
        end
        P_DEAD:  player_d = P_DEAD;
        default: player_d = P_ALIVE;
      endcase
    end else begin
      stomp_d = 1'b0;
    end
  end

  // State, counters and the registered output flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N_ENEMY; i++) begin
        enemy_q[i]  <= E_IDLE;
        sq_cnt_q[i] <= {SQW{1'b0}};
      end
      player_q   <= P_ALIVE;
      if_cnt_q   <= {IFW{1'b0}};
      lives_q    <= LV_LOAD;
      stomp_q    <= 1'b0;
      hit_q      <= 1'b0;
      hurt_q     <= 1'b0;
      dead_q     <= 1'b0;
      alive_q    <= {N_ENEMY{1'b0}};
      squashed_q <= {N_ENEMY{1'b0}};
    end else begin
      enemy_q  <= enemy_d;
      sq_cnt_q <= sq_cnt_d;
      player_q <= player_d;
      if_cnt_q <= if_cnt_d;
      lives_q  <= lives_d;
      stomp_q  <= stomp_d;
      hit_q    <= hit_d;
      hurt_q   <= (player_d == P_HURT);
      dead_q   <= (player_d == P_DEAD);
      for (int i = 0; i < N_ENEMY; i++) begin
        alive_q[i]    <= (enemy_d[i] == E_ALIVE);
        squashed_q[i] <= (enemy_d[i] == E_SQUASHED);
      end
    end
  end

  assign sr.enemy_alive    = alive_q;
  assign sr.enemy_squashed = squashed_q;
  assign sr.player_hurt    = hurt_q;
  assign sr.player_dead    = dead_q;
  assign sr.lives          = lives_q;
  assign sr.stomp_pulse    = stomp_q;
  assign sr.hit_pulse      = hit_q;
endmodule

// File: tb/tb_stomp_resolver.sv
// Bench for stomp_resolver: directed scenarios with literal expectations plus
// randomized frames checked every cycle against a behavioural model.
module tb_stomp_resolver;
  localparam int N  = 4;
  localparam int W  = 13;
  localparam int PS = 32;
  localparam int ES = 32;
  localparam int SQ = 30;
  localparam int IF = 60;
  localparam int LV = 3;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  stomp_resolver_if #(.N_ENEMY(N), .W(W), .LIVES(LV)) sr ();

  stomp_resolver #(
    .N_ENEMY(N), .W(W), .P_SIZE(PS), .E_SIZE(ES),
    .SQUASH_FRAMES(SQ), .IFRAMES(IF), .LIVES(LV)
  ) dut (
    .Clk(Clk), .Reset(Reset), .sr(sr)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // Model: squash frames left (0 = not squashed), dead/alive flags, lives, iframes left.
  int m_sq    [N];
  bit m_alive [N];
  bit m_dead  [N];
  int m_lives;
  int m_ifr;
  bit m_stomp;
  bit m_hit;

  function automatic bit ovl(int i);
    int px = int'(sr.player_x);
    int py = int'(sr.player_y);
    int ex = int'(sr.enemy_x[i*W +: W]);
    int ey = int'(sr.enemy_y[i*W +: W]);
    return (px < ex + ES) && (ex < px + PS) && (py < ey + ES) && (ey < py + PS);
  endfunction

  task automatic model_step();
    bit fall, anyc;
    bit c [N];
    m_stomp = 1'b0;
    m_hit   = 1'b0;
    if (Reset) begin
      for (int i = 0; i < N; i++) begin m_sq[i] = 0; m_alive[i] = 0; m_dead[i] = 0; end
      m_lives = LV;
      m_ifr   = 0;
      return;
    end
    if (sr.clear_all) begin
      for (int i = 0; i < N; i++) begin m_sq[i] = 0; m_alive[i] = 0; m_dead[i] = 0; end
      return;
    end
    if (!sr.frame_tick) return;
    fall = $signed(sr.player_y_motion) > 0;
    anyc = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i] = m_alive[i] && sr.enemy_active[i] && ovl(i);
      anyc = anyc | c[i];
    end
    if (m_lives > 0) begin
      m_stomp = fall && anyc;
      m_hit   = !fall && anyc && (m_ifr == 0);
    end
    for (int i = 0; i < N; i++) begin
      if (!m_dead[i]) begin
        if (m_sq[i] > 0) begin
          m_sq[i]--;
          if (m_sq[i] == 0) m_dead[i] = 1'b1;
        end else if (m_alive[i]) begin
          if (!sr.enemy_active[i]) m_alive[i] = 1'b0;
          else if (c[i] && m_stomp) begin m_alive[i] = 1'b0; m_sq[i] = SQ; end
        end else begin
          m_alive[i] = sr.enemy_active[i];
        end
      end
    end
    if (m_lives > 0) begin
      if (m_ifr > 0) m_ifr--;
      else if (m_hit) begin
        m_lives--;
        if (m_lives > 0) m_ifr = IF;
      end
    end
  endtask

  logic [N-1:0] e_alive, e_sq;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_alive[i] = m_alive[i];
        e_sq[i]    = (m_sq[i] > 0);
      end
      total_cnt++;
      if ({sr.enemy_alive, sr.enemy_squashed, sr.player_hurt, sr.player_dead,
           sr.lives, sr.stomp_pulse, sr.hit_pulse} !==
          {e_alive, e_sq, (m_ifr > 0), (m_lives == 0), 2'(m_lives), m_stomp, m_hit})
        $display("FAIL model_cmp t=%0t actual alive=%b sq=%b hurt=%b dead=%b lives=%0d st=%b hit=%b required alive=%b sq=%b hurt=%b dead=%b lives=%0d st=%b hit=%b",
                 $time, sr.enemy_alive, sr.enemy_squashed, sr.player_hurt, sr.player_dead,
                 sr.lives, sr.stomp_pulse, sr.hit_pulse, e_alive, e_sq, (m_ifr > 0),
                 (m_lives == 0), m_lives, m_stomp, m_hit);
      else
        pass_cnt++;
    end
  end

  task automatic lit(input string nm, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endtask

  task automatic cyc(input bit ft, input bit ca = 1'b0, input bit rs = 1'b0);
    sr.frame_tick = ft;
    sr.clear_all  = ca;
    Reset         = rs;
    @(posedge Clk);
    model_step();
    #1;
    sr.frame_tick = 1'b0;
    sr.clear_all  = 1'b0;
    Reset         = 1'b0;
  endtask

  task automatic place(input int i, input int x, input int y);
    sr.enemy_x[i*W +: W] = W'(x);
    sr.enemy_y[i*W +: W] = W'(y);
  endtask

  task automatic park();
    for (int i = 0; i < N; i++) place(i, 4000 + 100 * i, 4000);
    sr.enemy_active = 4'b0000;
  endtask

  task automatic set_player(input int x, input int y, input int mot);
    sr.player_x        = W'(x);
    sr.player_y        = W'(y);
    sr.player_y_motion = W'(mot);
  endtask

  initial begin
    Reset = 1'b1;
    sr.frame_tick = 1'b0;
    sr.clear_all  = 1'b0;
    set_player(0, 0, 0);
    park();
    cyc(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    lit("reset_lives", int'(sr.lives), 3);
    lit("reset_flags", int'({sr.enemy_alive, sr.player_hurt, sr.player_dead, sr.stomp_pulse}), 0);

    // Stomp and squash countdown
    set_player(100, 100, 0); place(0, 100, 120); sr.enemy_active = 4'b0001;
    cyc(1'b1);
    lit("spawn_alive", int'(sr.enemy_alive[0]), 1);
    sr.player_y_motion = 13'd3;
    cyc(1'b1);
    lit("stomp_sq", int'(sr.enemy_squashed[0]), 1);
    lit("stomp_pulse", int'(sr.stomp_pulse), 1);
    lit("stomp_lives", int'(sr.lives), 3);
    sr.player_y_motion = 13'd0;
    cyc(1'b0);
    lit("stomp_pulse_drop", int'(sr.stomp_pulse), 0);
    repeat (29) cyc(1'b1);
    lit("sq_29", int'(sr.enemy_squashed[0]), 1);
    cyc(1'b1);
    lit("sq_done", int'({sr.enemy_alive[0], sr.enemy_squashed[0]}), 0);

    // Side hit and iframes
    cyc(1'b0, 1'b0, 1'b1);
    park(); set_player(100, 200, 0); place(0, 131, 200); sr.enemy_active = 4'b0001;
    cyc(1'b1);
    lit("side_spawn_nohit", int'(sr.hit_pulse), 0);
    cyc(1'b1);
    lit("side_hit", int'(sr.hit_pulse), 1);
    lit("side_lives", int'(sr.lives), 2);
    lit("side_hurt", int'(sr.player_hurt), 1);
    cyc(1'b1);
    lit("iframe_nohit", int'(sr.hit_pulse), 0);
    repeat (58) cyc(1'b1);
    lit("iframe_59", int'(sr.player_hurt), 1);
    cyc(1'b1);
    lit("iframe_end", int'(sr.player_hurt), 0);

    // Exact edge and wrap-around
    cyc(1'b0, 1'b0, 1'b1);
    park(); set_player(100, 200, 0); place(0, 132, 200); sr.enemy_active = 4'b0001;
    cyc(1'b1); cyc(1'b1);
    lit("edge_nohit", int'({sr.hit_pulse, sr.stomp_pulse}), 0);
    set_player(0, 0, 0); place(0, 8160, 0);
    cyc(1'b1);
    lit("wrap_nohit", int'(sr.hit_pulse), 0);
    lit("wrap_lives", int'(sr.lives), 3);

    // Multi-enemy stomp, then the same geometry rising
    cyc(1'b0, 1'b0, 1'b1);
    park(); set_player(100, 100, 0); place(0, 100, 120); place(1, 110, 110);
    sr.enemy_active = 4'b0011;
    cyc(1'b1);
    sr.player_y_motion = 13'd1;
    cyc(1'b1);
    lit("multi_sq", int'(sr.enemy_squashed[1:0]), 3);
    lit("multi_stomp", int'(sr.stomp_pulse), 1);
    lit("multi_nohit", int'(sr.hit_pulse), 0);
    cyc(1'b0, 1'b0, 1'b1);
    sr.player_y_motion = 13'd0;
    cyc(1'b1);
    sr.player_y_motion = 13'h1FFE;
    cyc(1'b1);
    lit("multi_hit", int'(sr.hit_pulse), 1);
    lit("multi_hit_lives", int'(sr.lives), 2);

    // Death and what survives it
    cyc(1'b0, 1'b0, 1'b1);
    park(); set_player(100, 200, 0); place(0, 131, 200); sr.enemy_active = 4'b0001;
    cyc(1'b1);
    cyc(1'b1);
    lit("death_l2", int'(sr.lives), 2);
    repeat (60) cyc(1'b1);
    lit("death_l2_hold", int'(sr.lives), 2);
    cyc(1'b1);
    lit("death_l1", int'(sr.lives), 1);
    repeat (60) cyc(1'b1);
    cyc(1'b1);
    lit("death_l0", int'(sr.lives), 0);
    lit("death_flag", int'(sr.player_dead), 1);
    sr.player_y_motion = 13'd3;
    cyc(1'b1);
    lit("dead_nostomp", int'(sr.stomp_pulse), 0);
    lit("dead_enemy_alive", int'(sr.enemy_alive[0]), 1);
    sr.player_y_motion = 13'd0;
    cyc(1'b1);
    lit("dead_nohit", int'(sr.hit_pulse), 0);
    cyc(1'b0, 1'b1);
    lit("clear_idle", int'(sr.enemy_alive), 0);
    lit("clear_keeps_dead", int'(sr.player_dead), 1);
    cyc(1'b0, 1'b0, 1'b1);
    lit("reset_revive", int'(sr.lives), 3);

    // Reset mid-squash; clear_all colliding with a stomping tick
    park(); set_player(100, 100, 0); place(0, 100, 120); sr.enemy_active = 4'b0001;
    cyc(1'b1);
    sr.player_y_motion = 13'd3;
    cyc(1'b1);
    sr.player_y_motion = 13'd0;
    repeat (15) cyc(1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    lit("midsq_reset", int'({sr.enemy_squashed, sr.enemy_alive, sr.stomp_pulse}), 0);
    cyc(1'b1);
    sr.player_y_motion = 13'd3;
    cyc(1'b1, 1'b1);
    lit("clear_vs_stomp", int'({sr.enemy_alive[0], sr.enemy_squashed[0], sr.stomp_pulse}), 0);

    // Randomized frames around a crowded play area
    for (int n = 0; n < 5000; n++) begin
      set_player(200 + $urandom_range(0, 40), 200 + $urandom_range(0, 40), 0);
      case ($urandom_range(0, 5))
        0: sr.player_y_motion = 13'd0;
        1: sr.player_y_motion = W'($urandom_range(1, 3));
        2: sr.player_y_motion = W'(-int'($urandom_range(1, 3)));
        3: sr.player_y_motion = 13'h1000;
        4: sr.player_y_motion = 13'h0FFF;
        default: sr.player_y_motion = W'($urandom);
      endcase
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0)
          place(i, 8160 + $urandom_range(0, 31), $urandom_range(0, 8191));
        else
          place(i, 160 + $urandom_range(0, 120), 160 + $urandom_range(0, 120));
        sr.enemy_active[i] = ($urandom_range(0, 15) != 0);
      end
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 79) == 0, $urandom_range(0, 699) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/stomp_resolver.md
STOMP_RESOLVER -- requirements
Module: stomp_resolver

Interface
REQ-001 SHALL have parameter N_ENEMY, default 4: number of enemy channels.
REQ-002 SHALL have parameter W, default 13: coordinate and motion width.
REQ-003 SHALL have parameter P_SIZE, default 32: player box edge, pixels.
REQ-004 SHALL have parameter E_SIZE, default 32: enemy box edge, pixels.
REQ-005 SHALL have parameter SQUASH_FRAMES, default 30: frames an enemy shows its squashed sprite.
REQ-006 SHALL have parameter IFRAMES, default 60: player invulnerability frames after a hit.
REQ-007 SHALL have parameter LIVES, default 3: lives loaded at reset.
REQ-008 Clk  in  1  system clock, 50 MHz.
REQ-009 Reset  in  1  synchronous, active-high reset.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame; all evaluation happens only on this cycle.
REQ-011 clear_all  in  1  level restart; returns all enemies to IDLE.
REQ-012 player_x, player_y  in  W each  player top-left, unsigned.
REQ-013 player_y_motion  in  W  two's-complement; positive means falling.
REQ-014 enemy_x, enemy_y  in  N_ENEMY*W each  packed enemy top-left; channel i at [i*W +: W].
REQ-015 enemy_active  in  N_ENEMY  enemy i is spawned by its motion block.
REQ-016 enemy_alive, enemy_squashed  out  N_ENEMY each  per-enemy state flags.
REQ-017 player_hurt, player_dead  out  1 each  player state flags.
REQ-018 lives  out  $clog2(LIVES+1)  remaining lives.
REQ-019 stomp_pulse, hit_pulse  out  1 each  one-cycle event strobes.

Function
REQ-020 Overlap(i) SHALL be px < ex+E_SIZE && ex < px+P_SIZE && py < ey+E_SIZE && ey < py+P_SIZE; sums are computed in W+1 bits, so no wrap-around.
REQ-021 Falling SHALL be true when player_y_motion is nonzero and its MSB is 0.
REQ-022 Each enemy SHALL run an FSM with states IDLE, ALIVE, SQUASHED and DEAD, updated only on frame_tick cycles except where noted.
REQ-023 IDLE->ALIVE SHALL occur when enemy_active(i)=1.
REQ-024 ALIVE->IDLE SHALL occur when enemy_active(i)=0.
REQ-025 ALIVE->SQUASHED SHALL occur when Overlap(i), Falling, and the player is not DEAD; the squash counter loads SQUASH_FRAMES.
REQ-026 In SQUASHED, the squash counter SHALL decrement by 1 per frame_tick, with SQUASHED->DEAD on the tick where the counter equals 1.
REQ-027 DEAD SHALL be sticky until clear_all or Reset.
REQ-028 In SQUASHED and DEAD, an enemy SHALL never hurt the player.
REQ-029 clear_all SHALL act on any cycle, force every enemy to IDLE and zero its counters, take priority over frame_tick, and leave player state unchanged.
REQ-030 Player FSM states SHALL be ALIVE, HURT and DEAD.
REQ-031 A hit SHALL be defined as: player ALIVE, not Falling, and Overlap(i) with some enemy i in ALIVE; at most one hit is counted per frame regardless of enemy count.
REQ-032 On a hit, lives SHALL decrement by 1; if lives was 1, the player goes to DEAD with lives=0; otherwise the player goes to HURT with the iframe counter loaded with IFRAMES.
REQ-033 In HURT, no hits SHALL be taken and stomps SHALL still be resolved; the iframe counter decrements per frame_tick, with HURT->ALIVE on the tick where it equals 1.
REQ-034 DEAD SHALL be sticky until Reset; in DEAD, no stomps or hits are resolved.
REQ-035 Simultaneous overlaps while Falling SHALL squash every overlapping ALIVE enemy in the same frame and produce a single stomp_pulse.
REQ-036 A frame with stomps SHALL never produce a hit, since Falling excludes it.
REQ-037 All outputs SHALL be registered; state and flags change on the clock edge ending the frame_tick cycle (1-cycle latency).
REQ-038 stomp_pulse and hit_pulse SHALL each be high for exactly that one following cycle.
REQ-039 enemy_alive(i) SHALL be 1 iff enemy i is in ALIVE; enemy_squashed(i) SHALL be 1 iff it is in SQUASHED.
REQ-040 player_hurt SHALL be 1 iff the player is in HURT; player_dead SHALL be 1 iff the player is in DEAD.
REQ-041 Cycles without frame_tick or clear_all SHALL hold all state, with pulses at 0.

Reset
REQ-042 Reset SHALL be synchronous and take priority over clear_all and frame_tick.
REQ-043 Reset SHALL set all enemies to IDLE, the player to ALIVE, lives=LIVES, all counters to 0, and all flags and pulses to 0.
REQ-044 Reset asserted mid-squash or mid-iframe SHALL abandon the countdown immediately, with no residual pulse.

Verification
REQ-045 Stomp: p=(100,100), e0=(100,120), motion=+3, tick -> next cycle enemy_squashed[0]=1, stomp_pulse=1, lives=3; after 30 ticks enemy_alive[0]=0, enemy_squashed[0]=0.
REQ-046 Side hit: p=(100,200), e0=(131,200), motion=0, tick -> hit_pulse=1, lives=2, player_hurt=1; repeat tick with overlap -> no hit; after 60 ticks player_hurt=0.
REQ-047 Edge: p=(100,200), e0=(132,200), tick -> no overlap, no pulses; p=(0,0), e0=(8160,0) -> no overlap (wrap check).
REQ-048 Multi: e0 and e1 both overlap a player with motion=+1 -> both squashed, a single stomp_pulse; same geometry with motion=-2 (0x1FFE) -> one hit only, lives decrements by 1.
REQ-049 Death: three hits spaced more than 60 ticks apart -> lives 3,2,1,0, player_dead=1; further overlap -> no pulses; clear_all -> enemies IDLE, player_dead stays 1; Reset -> lives=3.
REQ-050 Reset mid-squash at counter=15 -> next cycle all flags 0; clear_all on the same cycle as a stomping tick -> enemy IDLE, no stomp_pulse.
